// File: rtl/rd_width_conv_fifo.sv
// rd_width_conv_fifo
// Single-clock wide-to-narrow buffering FIFO for the DDR read-return path.
// Wide words are written whole and read back as RATIO narrow slices, either
// least-significant slice first (LSB_FIRST=1) or most-significant first.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous clear of contents, levels and sticky flags
//   wr_en, wr_data      write one wide word
//   wr_full             storage holds 2^WR_DEPTH_WIDTH wide words
//   almost_full         wr_water_level >= ALMOST_FULL_NUM
//   wr_water_level      occupied wide words (partially read head counts)
//   rd_en, rd_data      read one narrow slice, data valid the cycle after
//   rd_empty            no unread slice
//   almost_empty        rd_water_level <= ALMOST_EMPTY_NUM
//   rd_water_level      unread narrow slices
//   overflow            sticky: write attempted while full
//   underflow           sticky: read attempted while empty
module rd_width_conv_fifo #(
  parameter int WR_DATA_WIDTH    = 256,
  parameter int RATIO            = 8,
  parameter int WR_DEPTH_WIDTH   = 9,
  parameter int ALMOST_FULL_NUM  = 508,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int LSB_FIRST        = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       flush,
  input  logic                                       wr_en,
  input  logic [WR_DATA_WIDTH-1:0]                   wr_data,
  output logic                                       wr_full,
  output logic                                       almost_full,
  output logic [WR_DEPTH_WIDTH:0]                    wr_water_level,
  input  logic                                       rd_en,
  output logic [WR_DATA_WIDTH/RATIO-1:0]             rd_data,
  output logic                                       rd_empty,
  output logic                                       almost_empty,
  output logic [WR_DEPTH_WIDTH+$clog2(RATIO):0]      rd_water_level,
  output logic                                       overflow,
  output logic                                       underflow
);

  localparam int RD_DATA_WIDTH  = WR_DATA_WIDTH / RATIO;
  localparam int SLICE_BITS     = $clog2(RATIO);
  // RATIO=1 still needs a one-bit index so the slice logic stays uniform.
  localparam int IDX_W          = (SLICE_BITS > 0) ? SLICE_BITS : 1;
  localparam int RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + SLICE_BITS;
  localparam int DEPTH          = 1 << WR_DEPTH_WIDTH;

  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [WR_DEPTH_WIDTH:0]   WL_ONE   = (WR_DEPTH_WIDTH+1)'(1);
  localparam logic [WR_DEPTH_WIDTH:0]   WL_DEPTH = (WR_DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [WR_DEPTH_WIDTH:0]   WL_AF    = (WR_DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [RD_DEPTH_WIDTH:0]   RL_ONE   = (RD_DEPTH_WIDTH+1)'(1);
  localparam logic [RD_DEPTH_WIDTH:0]   RL_RATIO = (RD_DEPTH_WIDTH+1)'(RATIO);
  localparam logic [RD_DEPTH_WIDTH:0]   RL_AE    = (RD_DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic                      AE_RESET = (ALMOST_EMPTY_NUM >= 0);

  logic [WR_DATA_WIDTH-1:0]  mem [DEPTH];
  logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
  logic [WR_DEPTH_WIDTH-1:0] rd_ptr;
  logic [IDX_W-1:0]          slice_idx;

  logic                      wr_acc;
  logic                      rd_acc;
  logic                      rd_last;
  logic [WR_DEPTH_WIDTH:0]   wr_level_nxt;
  logic [RD_DEPTH_WIDTH:0]   rd_level_nxt;
  logic [WR_DATA_WIDTH-1:0]  head_word;
  logic [IDX_W-1:0]          slice_sel;
  logic [RD_DATA_WIDTH-1:0]  cur_slice;

  // Acceptance uses the registered flags, so a write while full is dropped
  // even when the head word is released on the same edge.
  always_comb begin
    wr_acc  = wr_en & ~wr_full;
    rd_acc  = rd_en & ~rd_empty;
    rd_last = rd_acc & (slice_idx == LAST_IDX);

    // A partially read head word keeps counting until its last slice goes.
    wr_level_nxt = wr_water_level;
    if (wr_acc && !rd_last)
      wr_level_nxt = wr_water_level + WL_ONE;
    else if (!wr_acc && rd_last)
      wr_level_nxt = wr_water_level - WL_ONE;

    rd_level_nxt = rd_water_level;
    if (wr_acc)
      rd_level_nxt = rd_level_nxt + RL_RATIO;
    if (rd_acc)
      rd_level_nxt = rd_level_nxt - RL_ONE;
  end

  assign head_word = mem[rd_ptr];

  // Map the read-order index onto the physical slice position.
  always_comb begin
    slice_sel = (LSB_FIRST != 0) ? slice_idx : (LAST_IDX - slice_idx);
    cur_slice = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (slice_sel == IDX_W'(k))
        cur_slice = head_word[k*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
  end

  // Storage is not reset; data written during a flush is discarded.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      slice_idx      <= '0;
      rd_data        <= '0;
      wr_water_level <= '0;
      rd_water_level <= '0;
      wr_full        <= 1'b0;
      almost_full    <= 1'b0;
      rd_empty       <= 1'b1;
      almost_empty   <= AE_RESET;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else if (flush) begin
      // rd_data deliberately holds its last value across a flush.
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      slice_idx      <= '0;
      wr_water_level <= '0;
      rd_water_level <= '0;
      wr_full        <= 1'b0;
      almost_full    <= 1'b0;
      rd_empty       <= 1'b1;
      almost_empty   <= AE_RESET;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + WR_DEPTH_WIDTH'(1);
      if (rd_acc) begin
        rd_data <= cur_slice;
        if (rd_last) begin
          slice_idx <= '0;
          rd_ptr    <= rd_ptr + WR_DEPTH_WIDTH'(1);
        end else begin
          slice_idx <= slice_idx + IDX_W'(1);
        end
      end
      // Flags are computed from the post-edge levels so they match them.
      wr_water_level <= wr_level_nxt;
      rd_water_level <= rd_level_nxt;
      wr_full        <= (wr_level_nxt == WL_DEPTH);
      almost_full    <= (wr_level_nxt >= WL_AF);
      rd_empty       <= (rd_level_nxt == '0);
      almost_empty   <= AE_RESET && (rd_level_nxt <= RL_AE);
      if (wr_en && wr_full)
        overflow <= 1'b1;
      if (rd_en && rd_empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_width_conv_fifo.sv
// Testbench for rd_width_conv_fifo: a slice-queue reference model (levels are
// derived from the number of unread slices) checked against the default
// LSB-first instance, plus a second instance built most-significant first.
module tb_rd_width_conv_fifo;

  localparam int WR    = 256;
  localparam int RATIO = 8;
  localparam int RD    = 32;
  localparam int DEPTH = 512;
  localparam int AF    = 508;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_en, rd_en;
  logic [WR-1:0] wr_data;
  logic          wr_full, almost_full, rd_empty, almost_empty, overflow, underflow;
  logic [9:0]    wr_water_level;
  logic [12:0]   rd_water_level;
  logic [RD-1:0] rd_data;

  logic          m_flush, m_wr_en, m_rd_en;
  logic [WR-1:0] m_wr_data;
  logic          m_wr_full, m_almost_full, m_rd_empty, m_almost_empty, m_overflow, m_underflow;
  logic [9:0]    m_wr_water_level;
  logic [12:0]   m_rd_water_level;
  logic [RD-1:0] m_rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: unread narrow slices in read order.
  logic [RD-1:0] mq[$];
  logic [RD-1:0] exp_rd;
  bit            exp_ovf, exp_unf;

  always #5 clk = ~clk;

  rd_width_conv_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty),
    .rd_water_level(rd_water_level), .overflow(overflow), .underflow(underflow)
  );

  rd_width_conv_fifo #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .flush(m_flush), .wr_en(m_wr_en), .wr_data(m_wr_data),
    .wr_full(m_wr_full), .almost_full(m_almost_full), .wr_water_level(m_wr_water_level),
    .rd_en(m_rd_en), .rd_data(m_rd_data), .rd_empty(m_rd_empty), .almost_empty(m_almost_empty),
    .rd_water_level(m_rd_water_level), .overflow(m_overflow), .underflow(m_underflow)
  );

  function automatic int m_rl();
    return mq.size();
  endfunction

  function automatic int m_wl();
    return (mq.size() + RATIO - 1) / RATIO;
  endfunction

  function automatic logic [WR-1:0] rand_word();
    logic [WR-1:0] w;
    for (int k = 0; k < WR/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [WR-1:0] byte_ramp_word();
    logic [WR-1:0] w;
    for (int b = 0; b < WR/8; b++) w[b*8 +: 8] = 8'(b);
    return w;
  endfunction

  // Four consecutive byte values starting at base, lowest byte first.
  function automatic logic [RD-1:0] ramp_slice(input int base);
    logic [RD-1:0] s;
    for (int j = 0; j < 4; j++) s[j*8 +: 8] = 8'(base + j);
    return s;
  endfunction

  function automatic void model_reset();
    mq.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endfunction

  // Drive one cycle on the main instance and advance the model.
  task automatic step(input bit w, input logic [WR-1:0] d, input bit r, input bit f);
    bit wacc, racc;
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      wacc = w && (m_wl() < DEPTH);
      racc = r && (mq.size() > 0);
      if (w && !wacc) exp_ovf = 1'b1;
      if (r && !racc) exp_unf = 1'b1;
      if (racc) exp_rd = mq.pop_front();
      if (wacc) for (int k = 0; k < RATIO; k++) mq.push_back(d[k*RD +: RD]);
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (rd_data !== '0) begin errors++; $display("[TB] FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_full got %b exp 0", wr_full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_almost_full got %b exp 0", almost_full); end
    checks++; if (wr_water_level !== '0) begin errors++; $display("[TB] FAIL reset_wr_level got %0d exp 0", wr_water_level); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rd_empty got %b exp 1", rd_empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_almost_empty got %b exp 1", almost_empty); end
    checks++; if (rd_water_level !== '0) begin errors++; $display("[TB] FAIL reset_rd_level got %0d exp 0", rd_water_level); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky got ovf=%b unf=%b exp 0 0", overflow, underflow); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    logic [WR-1:0] w;
    w = byte_ramp_word();
    step(1'b1, w, 1'b0, 1'b0);
    checks++; if (rd_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_after_wr got %b exp 0", rd_empty); end
    checks++; if (rd_water_level !== 13'd8) begin errors++; $display("[TB] FAIL single_rd_level_wr got %0d exp 8", rd_water_level); end
    for (int k = 0; k < RATIO; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (rd_data !== ramp_slice(4*k) || rd_data !== exp_rd) begin errors++; $display("[TB] FAIL single_rd_data k=%0d got %h exp %h", k, rd_data, ramp_slice(4*k)); end
      checks++; if (rd_water_level !== 13'(7 - k)) begin errors++; $display("[TB] FAIL single_rd_level k=%0d got %0d exp %0d", k, rd_water_level, 7 - k); end
      checks++; if (wr_water_level !== ((k == 7) ? 10'd0 : 10'd1)) begin errors++; $display("[TB] FAIL single_wr_level k=%0d got %0d exp %0d", k, wr_water_level, (k == 7) ? 0 : 1); end
      checks++; if (rd_empty !== (k == 7)) begin errors++; $display("[TB] FAIL single_rd_empty k=%0d got %b exp %b", k, rd_empty, k == 7); end
    end
  endtask

  task automatic test_underflow();
    logic [RD-1:0] prev;
    prev = rd_data;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (rd_data !== prev) begin errors++; $display("[TB] FAIL underflow_rd_data i=%0d got %h exp %h", i, rd_data, prev); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL underflow_flag i=%0d got %b exp 1", i, underflow); end
      checks++; if (wr_water_level !== '0 || rd_water_level !== '0) begin errors++; $display("[TB] FAIL underflow_levels i=%0d got %0d/%0d exp 0/0", i, wr_water_level, rd_water_level); end
    end
  endtask

  task automatic test_flush();
    logic [RD-1:0] prev;
    for (int i = 0; i < 100; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (wr_water_level !== 10'd100) begin errors++; $display("[TB] FAIL flush_pre_level got %0d exp 100", wr_water_level); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_underflow got %b exp 1", underflow); end
    prev = rd_data;
    step(1'b1, rand_word(), 1'b1, 1'b1);
    checks++; if (wr_water_level !== '0 || rd_water_level !== '0) begin errors++; $display("[TB] FAIL flush_levels got %0d/%0d exp 0/0", wr_water_level, rd_water_level); end
    checks++; if (rd_empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty got %b/%b exp 1/1", rd_empty, almost_empty); end
    checks++; if (wr_full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL flush_full got %b/%b exp 0/0", wr_full, almost_full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL flush_sticky got %b/%b exp 0/0", overflow, underflow); end
    checks++; if (rd_data !== prev) begin errors++; $display("[TB] FAIL flush_rd_data got %h exp %h", rd_data, prev); end
    // The write in the flush cycle must not have landed.
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b1 || rd_data !== prev) begin errors++; $display("[TB] FAIL flush_discard got unf=%b data=%h exp 1 %h", underflow, rd_data, prev); end
  endtask

  task automatic test_fill_drain();
    int guard;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, rand_word(), 1'b0, 1'b0);
      checks++; if (wr_water_level !== 10'(m_wl())) begin errors++; $display("[TB] FAIL fill_wr_level i=%0d got %0d exp %0d", i, wr_water_level, m_wl()); end
      checks++; if (almost_full !== (m_wl() >= AF)) begin errors++; $display("[TB] FAIL fill_almost_full i=%0d got %b exp %b", i, almost_full, m_wl() >= AF); end
      checks++; if (wr_full !== (m_wl() == DEPTH)) begin errors++; $display("[TB] FAIL fill_wr_full i=%0d got %b exp %b", i, wr_full, m_wl() == DEPTH); end
    end
    step(1'b1, rand_word(), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1 || wr_water_level !== 10'd512) begin errors++; $display("[TB] FAIL fill_overflow got ovf=%b lvl=%0d exp 1 512", overflow, wr_water_level); end
    guard = 0;
    while (mq.size() > 0 && guard < 20000) begin
      step(1'b0, '0, ($urandom_range(0, 3) != 0), 1'b0);
      guard++;
      checks++; if (rd_data !== exp_rd) begin errors++; $display("[TB] FAIL drain_rd_data left=%0d got %h exp %h", m_rl(), rd_data, exp_rd); end
      checks++; if (rd_water_level !== 13'(m_rl())) begin errors++; $display("[TB] FAIL drain_rd_level got %0d exp %0d", rd_water_level, m_rl()); end
      checks++; if (almost_empty !== (m_rl() <= AE)) begin errors++; $display("[TB] FAIL drain_almost_empty lvl=%0d got %b exp %b", m_rl(), almost_empty, m_rl() <= AE); end
    end
    checks++; if (guard >= 20000) begin errors++; $display("[TB] FAIL drain_timeout got %0d slices left exp 0", m_rl()); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_rd_empty got %b exp 1", rd_empty); end
  endtask

  task automatic test_full_simul();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < RATIO - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, rand_word(), 1'b1, 1'b0);
    checks++; if (rd_data !== exp_rd) begin errors++; $display("[TB] FAIL simul_rd_data got %h exp %h", rd_data, exp_rd); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL simul_overflow got %b exp 1", overflow); end
    checks++; if (wr_water_level !== 10'd511 || wr_full !== 1'b0) begin errors++; $display("[TB] FAIL simul_level got %0d full=%b exp 511 0", wr_water_level, wr_full); end
    checks++; if (rd_water_level !== 13'd4088) begin errors++; $display("[TB] FAIL simul_rd_level got %0d exp 4088", rd_water_level); end
  endtask

  task automatic test_random();
    bit w, r, f;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 99) == 0);
      step(w, rand_word(), r, f);
      checks++;
      if (rd_data !== exp_rd || rd_water_level !== 13'(m_rl()) || wr_water_level !== 10'(m_wl()) ||
          wr_full !== (m_wl() == DEPTH) || almost_full !== (m_wl() >= AF) ||
          rd_empty !== (m_rl() == 0) || almost_empty !== (m_rl() <= AE) ||
          overflow !== exp_ovf || underflow !== exp_unf) begin
        errors++;
        $display("[TB] FAIL random i=%0d got data=%h rl=%0d wl=%0d full=%b af=%b emp=%b ae=%b ovf=%b unf=%b exp data=%h rl=%0d wl=%0d ovf=%b unf=%b",
                 i, rd_data, rd_water_level, wr_water_level, wr_full, almost_full, rd_empty, almost_empty,
                 overflow, underflow, exp_rd, m_rl(), m_wl(), exp_ovf, exp_unf);
      end
    end
  endtask

  task automatic test_reset_midburst();
    logic [WR-1:0] w;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_water_level !== '0 || rd_water_level !== '0) begin errors++; $display("[TB] FAIL midrst_levels got %0d/%0d exp 0/0", wr_water_level, rd_water_level); end
    checks++; if (rd_data !== '0 || rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL midrst_outputs got %h emp=%b exp 0 1", rd_data, rd_empty); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    w = rand_word();
    step(1'b1, w, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (rd_data !== w[RD-1:0] || rd_data !== exp_rd) begin errors++; $display("[TB] FAIL midrst_first_slice got %h exp %h", rd_data, w[RD-1:0]); end
  endtask

  task automatic test_msb_first();
    logic [WR-1:0] w;
    w = byte_ramp_word();
    m_wr_en = 1'b1; m_wr_data = w;
    @(posedge clk);
    #1;
    m_wr_en = 1'b0;
    checks++; if (m_rd_water_level !== 13'd8) begin errors++; $display("[TB] FAIL msb_rd_level got %0d exp 8", m_rd_water_level); end
    for (int k = 0; k < RATIO; k++) begin
      m_rd_en = 1'b1;
      @(posedge clk);
      #1;
      m_rd_en = 1'b0;
      checks++; if (m_rd_data !== ramp_slice(28 - 4*k)) begin errors++; $display("[TB] FAIL msb_rd_data k=%0d got %h exp %h", k, m_rd_data, ramp_slice(28 - 4*k)); end
    end
    checks++; if (m_rd_empty !== 1'b1) begin errors++; $display("[TB] FAIL msb_rd_empty got %b exp 1", m_rd_empty); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    m_flush = 1'b0; m_wr_en = 1'b0; m_rd_en = 1'b0; m_wr_data = '0;
    model_reset();
    test_reset();
    test_single_word();
    test_underflow();
    test_flush();
    test_fill_drain();
    test_full_simul();
    test_random();
    test_reset_midburst();
    test_msb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_width_conv_fifo.md
Name: rd_width_conv_fifo

Overview:
- Single-clock, parametrised wide-to-narrow buffering FIFO for the DDR read-return path.
- Wide words written at WR_DATA_WIDTH are read back as RATIO narrow slices of WR_DATA_WIDTH/RATIO bits, in a selectable slice order.
- Adds a synchronous flush, sticky overflow/underflow flags and slice-accurate water levels.
- Sits between the DDR read burst engine and the pixel-side consumers when both run in one clock domain.

Parameters:
- WR_DATA_WIDTH, 256: wide write word width; must be divisible by RATIO.
- RATIO, 8: narrow slices per wide word; power of two, 1..32.
- WR_DEPTH_WIDTH, 9: log2 of storage depth in wide words (depth 512).
- ALMOST_FULL_NUM, 508: almost_full threshold, in wide words.
- ALMOST_EMPTY_NUM, 4: almost_empty threshold, in narrow words.
- LSB_FIRST, 1: 1 = slice [RD_DATA_WIDTH-1:0] is read first; 0 = most-significant slice first.
- Derived localparams: RD_DATA_WIDTH = WR_DATA_WIDTH/RATIO; RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + log2(RATIO).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous clear of contents and flags.
- wr_en  in  1  write request, one wide word.
- wr_data  in  WR_DATA_WIDTH  write data.
- wr_full  out  1  full flag.
- almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM.
- wr_water_level  out  WR_DEPTH_WIDTH+1  occupied wide words.
- rd_en  in  1  read request, one narrow slice.
- rd_data  out  RD_DATA_WIDTH  read data.
- rd_empty  out  1  no unread slice.
- almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM.
- rd_water_level  out  RD_DEPTH_WIDTH+1  unread narrow slices.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n=0, async): all pointers, slice index and counts cleared.
  - rd_data=0, wr_full=0, almost_full=0, wr_water_level=0.
  - rd_empty=1, almost_empty=1 (when ALMOST_EMPTY_NUM>=0), rd_water_level=0.
  - overflow=0, underflow=0.
- Storage: 2^WR_DEPTH_WIDTH wide words; write pointer and read pointer in wide words, plus a log2(RATIO)-bit slice index.
- Status outputs: all registered, and updated on the same edge as the pointers so they reflect the post-edge state.
- Write accept = wr_en & ~wr_full, using the registered wr_full.
  - A write while wr_full=1 is dropped and sets overflow, even if the head word is released in the same cycle.
- Read accept = rd_en & ~rd_empty, using the registered rd_empty.
  - Accepted read: rd_data loads the current slice on that edge (latency 1), and the slice index increments.
  - On the last slice (index RATIO-1) the index wraps to 0 and the read pointer advances one wide word.
  - Read while rd_empty=1: rd_data holds its value, state is unchanged, underflow is set.
- Slice select: LSB_FIRST=1 → slice k = word[k*RD+RD-1 : k*RD]; LSB_FIRST=0 → slice k = word[WR-1-k*RD : WR-RD-k*RD].
- wr_water_level counts wide words; a partially read head word still counts until its last slice is read.
  - Write and last-slice read in the same cycle → count unchanged.
- rd_water_level = wr_water_level*RATIO − slice_index. It is maintained consistently, not recomputed combinationally at the output.
- Flags:
  - wr_full = (wr_water_level == 2^WR_DEPTH_WIDTH).
  - rd_empty = (rd_water_level == 0).
  - First write into an empty FIFO: rd_empty deasserts in the cycle after the write edge.
- Pointers are WR_DEPTH_WIDTH bits and wrap modulo depth; the count distinguishes full from empty.
- flush=1 has priority over wr_en and rd_en in the same cycle.
  - Clears pointers, slice index, counts, overflow and underflow.
  - Flags return to reset values on that edge; rd_data holds.
  - Write data presented in a flush cycle is discarded.
- rst_n asserted mid-burst: immediate clear; the first read after release returns the first slice of the next written word.

Test Plan:
- Defaults; write 1 word with byte b = b (0x1F1E…0100); read 8 → rd_data 0x03020100, 0x07060504 … 0x1F1E1D1C. rd_water_level goes 8,7,…,0; rd_empty=1 after the 8th read; wr_water_level drops 1→0 only on the 8th read.
- Write 512 distinct words → almost_full=1 from level 508, wr_full=1 at 512. The 513th write is dropped and overflow=1. Drain 4096 slices → order intact, final rd_empty=1, almost_empty asserted at rd_water_level 4.
- Empty FIFO, rd_en for 3 cycles → rd_data unchanged, underflow=1 sticky, levels stay 0.
- Full FIFO with slice index 7; assert rd_en and wr_en together → read accepted, write dropped, overflow=1. Next cycle wr_water_level=511, wr_full=0.
- Level 100 words with flush, wr_en and rd_en asserted together → next cycle both levels 0, rd_empty=1, wr_full=0, overflow=0, underflow=0, rd_data unchanged.
- LSB_FIRST=0, same word as scenario 1 → first read 0x1F1E1D1C, last read 0x03020100.
